// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: blank pattern and
// active-low polarity of anodes and segments.
package seg_pkg;

   localparam int unsigned NIB_W     = 4;
   localparam int unsigned SEG_W     = 7;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
   localparam logic SEG_ON  = 1'b0;
   localparam logic SEG_OFF = 1'b1;
   localparam logic AN_ON   = 1'b0;
   localparam logic AN_OFF  = 1'b1;

endpackage

// File: rtl/seg_scan_ctrl_led_disp.sv
// Hex nibble to active-low 7-segment pattern (bit 6 = a ... bit 0 = g).
module led_disp
   import seg_pkg::*;
(
   input  logic [NIB_W-1:0] i_hex,
   output logic [SEG_W-1:0] o_seg_c
);

   always_comb begin
      o_seg_c = SEG_BLANK;
      case (i_hex)
         4'h0: o_seg_c = 7'b0000001;
         4'h1: o_seg_c = 7'b1001111;
         4'h2: o_seg_c = 7'b0010010;
         4'h3: o_seg_c = 7'b0000110;
         4'h4: o_seg_c = 7'b1001100;
         4'h5: o_seg_c = 7'b0100100;
         4'h6: o_seg_c = 7'b0100000;
         4'h7: o_seg_c = 7'b0001111;
         4'h8: o_seg_c = 7'b0000000;
         4'h9: o_seg_c = 7'b0000100;
         4'hA: o_seg_c = 7'b0001000;
         4'hB: o_seg_c = 7'b1100000;
         4'hC: o_seg_c = 7'b0110001;
         4'hD: o_seg_c = 7'b1000010;
         4'hE: o_seg_c = 7'b0110000;
         4'hF: o_seg_c = 7'b0111000;
         default: o_seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered display value.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned PRESCALE = 50000
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [NIB_W*DIGITS-1:0]   in_value,
   output logic                      in_ready,
   input  logic [DIGITS-1:0]         blank_i,
   input  logic [DIGITS-1:0]         dp_i,
   output logic [SEG_W-1:0]          seg_o,
   output logic                      dp_o,
   output logic [DIGITS-1:0]         an_o,
   output logic                      frame_o
);

   localparam int unsigned CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam int unsigned IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;
   localparam int unsigned VAL_W = NIB_W * DIGITS;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic [VAL_W-1:0]  r_disp;
   logic [VAL_W-1:0]  r_pend;
   logic              r_pend_full;
   logic [SEG_W-1:0]  r_seg;
   logic              r_dp;
   logic [DIGITS-1:0] r_an;
   logic              r_frame;

   logic              w_tick;
   logic              w_last;
   logic              w_xfer;
   logic              w_commit;
   logic [NIB_W-1:0]  w_nib;
   logic [SEG_W-1:0]  w_dec;
   logic              w_lzb;
   logic              w_dark;
   logic [SEG_W-1:0]  w_seg_nxt;
   logic              w_dp_nxt;
   logic [DIGITS-1:0] w_an_nxt;

   assign w_tick   = (r_cnt == CNT_LAST);
   assign w_last   = (r_idx == IDX_LAST);
   assign w_xfer   = in_valid & ~r_pend_full;
   assign w_commit = w_tick & w_last & r_pend_full;
   assign w_nib    = NIB_W'(r_disp >> {r_idx, 2'b00});

   led_disp u_led_disp (
      .i_hex   (w_nib),
      .o_seg_c (w_dec)
   );

`ifdef SEG_SCAN_LZB_EN
   logic [DIGITS-1:0] w_lz;

   // A digit is a leading zero when it and every digit above it are zero
   always_comb begin
      logic zero_above;
      w_lz       = '0;
      zero_above = 1'b1;
      for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
         zero_above = zero_above & (r_disp[NIB_W*k +: NIB_W] == '0);
         w_lz[k]    = zero_above;
      end
   end

   assign w_lzb = w_lz[r_idx];
`else
   assign w_lzb = 1'b0;
`endif

   assign w_dark = blank_i[r_idx] | w_lzb;

   // Next values for the pin registers: guard slot, blanked digit, or lit digit
   always_comb begin
      w_an_nxt  = {DIGITS{AN_OFF}};
      w_seg_nxt = SEG_BLANK;
      w_dp_nxt  = SEG_OFF;
      if (!w_tick) begin
         w_an_nxt = ~(DIGITS'(1) << r_idx);
         if (!w_dark) begin
            w_seg_nxt = w_dec;
            w_dp_nxt  = ~dp_i[r_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else begin
         r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
         if (w_tick) begin
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
         end
      end
   end

   // Transfer and commit are mutually exclusive since ready is low while full
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_disp      <= '0;
         r_pend      <= '0;
         r_pend_full <= 1'b0;
      end else if (w_xfer) begin
         r_pend      <= in_value;
         r_pend_full <= 1'b1;
      end else if (w_commit) begin
         r_disp      <= r_pend;
         r_pend_full <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_an    <= {DIGITS{AN_OFF}};
         r_seg   <= SEG_BLANK;
         r_dp    <= SEG_OFF;
         r_frame <= 1'b0;
      end else begin
         r_an    <= w_an_nxt;
         r_seg   <= w_seg_nxt;
         r_dp    <= w_dp_nxt;
         r_frame <= w_tick & w_last;
      end
   end

   assign in_ready = ~r_pend_full;
   assign an_o     = r_an;
   assign seg_o    = r_seg;
   assign dp_o     = r_dp;
   assign frame_o  = r_frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized and directed bench for seg_scan_ctrl against a time-based
// behavioural model (DIGITS=4, PRESCALE=4).
module tb_seg_scan_ctrl;

   localparam int unsigned D = 4;
   localparam int unsigned P = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_value;
   logic        in_ready;
   logic [3:0]  blank_i;
   logic [3:0]  dp_i;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic [3:0]  an_o;
   logic        frame_o;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_value (in_value),
      .in_ready (in_ready),
      .blank_i  (blank_i),
      .dp_i     (dp_i),
      .seg_o    (seg_o),
      .dp_o     (dp_o),
      .an_o     (an_o),
      .frame_o  (frame_o)
   );

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] tbl [16];
      tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      return tbl[n];
   endfunction

   // Model: slot position derived from cycles elapsed since reset
   int          m_t;
   logic [15:0] m_disp, m_pend;
   logic        m_pf;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp, e_frame;

   always @(posedge clk) begin : model
      int c, k;
      logic tk, lz;
      logic [15:0] above;
      logic [3:0] one;
      if (!rst_n) begin
         m_t <= 0; m_disp <= '0; m_pend <= '0; m_pf <= 1'b0;
         e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_frame <= 1'b0;
      end else begin
         c     = m_t % P;
         k     = (m_t / P) % D;
         tk    = (c == P - 1);
         above = m_disp >> (4 * k);
         one   = 4'b0001;
         lz    = 1'b0;
`ifdef SEG_SCAN_LZB_EN
         lz = (k >= 1) && (above == 16'h0);
`endif
         if (tk) begin
            e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1;
         end else begin
            e_an <= ~(one << k);
            if (blank_i[k] || lz) begin
               e_seg <= 7'h7F; e_dp <= 1'b1;
            end else begin
               e_seg <= hex7(above[3:0]); e_dp <= ~dp_i[k];
            end
         end
         e_frame <= tk && (k == D - 1);
         if (tk && (k == D - 1) && m_pf) begin
            m_disp <= m_pend; m_pf <= 1'b0;
         end else if (in_valid && !m_pf) begin
            m_pend <= in_value; m_pf <= 1'b1;
         end
         m_t <= m_t + 1;
      end
   end

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Advance one cycle and compare all outputs against the model
   task automatic cyc();
      @(negedge clk);
      if (chk_en) begin
         chk("an_o", 16'(an_o), 16'(e_an));
         chk("seg_o", 16'(seg_o), 16'(e_seg));
         chk("dp_o", 16'(dp_o), 16'(e_dp));
         chk("frame_o", 16'(frame_o), 16'(e_frame));
         chk("in_ready", 16'(in_ready), 16'(!m_pf));
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timed out at %0t", nm, $time);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (in_ready !== 1'b1 && n < 200) begin cyc(); n++; end
      if (n >= 200) timeout("wait_ready");
   endtask

   task automatic wait_digit(input int k);
      int n = 0;
      logic [3:0] one = 4'b0001;
      do begin cyc(); n++; end while (an_o !== ~(one << k) && n < 100);
      if (n >= 100) timeout("wait_digit");
   endtask

   task automatic send(input logic [15:0] v);
      wait_ready();
      in_valid = 1'b1;
      in_value = v;
      cyc();
      in_valid = 1'b0;
      in_value = 16'($urandom);
   endtask

   initial begin
      int frames;
      rst_n = 1'b0; in_valid = 1'b0; in_value = '0; blank_i = '0; dp_i = '0;
      @(negedge clk);
      chk_en = 1'b1;
      repeat (3) cyc();
      chk("rst_an", 16'(an_o), 16'(4'b1111));
      chk("rst_seg", 16'(seg_o), 16'(7'b1111111));
      chk("rst_ready", 16'(in_ready), 16'(1'b1));
      rst_n = 1'b1;
      cyc();
      chk("first_an", 16'(an_o), 16'(4'b1110));
      chk("first_seg", 16'(seg_o), 16'(7'b0000001));

      frames = 0;
      repeat (32) begin cyc(); if (frame_o) frames++; end
      chk("frame_count", 16'(frames), 16'(2));

      repeat (5) cyc();
      send(16'h1234);
      chk("ready_drop", 16'(in_ready), 16'(1'b0));
      wait_ready();
      wait_digit(0);
      chk("commit_d0", 16'(seg_o), 16'(7'b1001100));

      blank_i = 4'b0100; dp_i = 4'b0001;
      send(16'h8888);
      wait_ready();
      wait_digit(2);
      chk("blank_d2", 16'(seg_o), 16'(7'b1111111));
      wait_digit(0);
      chk("dp_d0", 16'(dp_o), 16'(1'b0));
      chk("seg8_d0", 16'(seg_o), 16'(7'b0000000));

      blank_i = '0; dp_i = '0;
      send(16'h0042);
      wait_ready();
      wait_digit(3);
`ifdef SEG_SCAN_LZB_EN
      chk("lz_d3", 16'(seg_o), 16'(7'b1111111));
`else
      chk("lz_d3", 16'(seg_o), 16'(7'b0000001));
`endif
      wait_digit(1);
      chk("d1_four", 16'(seg_o), 16'(7'b1001100));
      send(16'h0000);
      wait_ready();
      wait_digit(0);
      chk("zero_d0", 16'(seg_o), 16'(7'b0000001));

      for (int i = 0; i < 800; i++) begin
         in_valid = ($urandom % 4 == 0);
         in_value = 16'($urandom);
         blank_i  = ($urandom % 4 == 0) ? 4'($urandom) : 4'b0000;
         dp_i     = 4'($urandom);
         cyc();
      end
      in_valid = 1'b0; blank_i = '0; dp_i = '0;

      wait_ready();
      send(16'h5555);
      wait_digit(2);
      chk("pend_full", 16'(in_ready), 16'(1'b0));
      rst_n = 1'b0;
      cyc();
      chk("mid_rst_ready", 16'(in_ready), 16'(1'b1));
      chk("mid_rst_an", 16'(an_o), 16'(4'b1111));
      rst_n = 1'b1;
      repeat (48) cyc();
      wait_digit(0);
      chk("discarded", 16'(seg_o), 16'(7'b0000001));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
